// File: rtl/viterbi_pkg.sv
// Shared definitions for the hard-decision Viterbi decoder control path.
package viterbi_pkg;

    // Sequencer states; IDLE must stay at encoding 0 so reset lands there.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_DECODE = 3'd2,
        S_FLUSH  = 3'd3,
        S_TRACE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int FRAME_LEN_DEF = 16;
    localparam int SYM_W         = 2;

    // Path metrics clear to 0 for state 0 and to all-ones elsewhere.
    localparam int               PM_W        = 8;
    localparam logic [PM_W-1:0]  PM_INIT_MAX = '1;

endpackage

// File: rtl/viterbi_control_frame_counter.sv
// Symbol/traceback index counter with clear, load, up/down count and a
// terminal-count compare. Decrement saturates at 0 so addresses never wrap.
module frame_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] cnt,
    output logic             at_tc
);

    // Counter register: clear wins over load, load over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign at_tc = (cnt == tc_val);

endmodule

// File: rtl/viterbi_control.sv
// Top-level sequencer: accepts one frame of symbols, drives the branch
// metric / ACS / survivor enables, then steps traceback from the last
// survivor address down to 0.
//
//  state  | meaning
//  IDLE   | waiting for i_start, all enables low
//  INIT   | one-cycle path-metric clear, symbol counter cleared
//  DECODE | accepting symbols, one per clock at most
//  FLUSH  | enables for the final symbol, traceback counter loaded
//  TRACE  | one traceback step per cycle while i_out_ready
//  DONE   | one-cycle o_done pulse
module viterbi_control
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [SYM_W-1:0] i_Rx,
    output logic             o_ready,
    output logic [SYM_W-1:0] o_Rx,
    output logic             en_branch,
    output logic             en_acs,
    output logic             en_mem,
    output logic [CNT_W-1:0] o_wr_addr,
    output logic             o_init_pm,
    input  logic             i_out_ready,
    output logic             en_trace,
    output logic [CNT_W-1:0] o_rd_addr,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             en_dp;
    logic [CNT_W-1:0] sym_cnt;
    logic             sym_last;
    logic [CNT_W-1:0] trace_cnt;
    logic             trace_zero;

    assign accept = (state == S_DECODE) && i_valid && o_ready;

    frame_counter #(.CNT_W(CNT_W)) u_sym_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == S_INIT),
        .load     (1'b0),
        .load_val ('0),
        .inc      (accept),
        .dec      (1'b0),
        .tc_val   (LAST_IDX),
        .cnt      (sym_cnt),
        .at_tc    (sym_last)
    );

    frame_counter #(.CNT_W(CNT_W)) u_trace_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (state == S_FLUSH),
        .load_val (LAST_IDX),
        .inc      (1'b0),
        .dec      (en_trace),
        .tc_val   ('0),
        .cnt      (trace_cnt),
        .at_tc    (trace_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs; en_trace is the only
    // output that looks straight through to an input.
    always_comb begin
        state_nxt = state;
        o_init_pm = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        en_trace  = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) state_nxt = S_INIT;
            end
            S_INIT: begin
                o_init_pm = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (accept && sym_last) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                state_nxt = S_TRACE;
            end
            S_TRACE: begin
                en_trace = i_out_ready;
                if (i_out_ready && trace_zero) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Symbol capture and datapath enables; the enables trail acceptance by
    // one cycle so they line up with the registered symbol and address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_ready   <= 1'b0;
            o_Rx      <= '0;
            o_wr_addr <= '0;
            en_dp     <= 1'b0;
        end else begin
            en_dp <= accept;
            if (accept) begin
                o_Rx      <= i_Rx;
                o_wr_addr <= sym_cnt;
            end
            if (state == S_INIT) begin
                o_ready <= 1'b1;
            end else if ((state != S_DECODE) || (accept && sym_last)) begin
                o_ready <= 1'b0;
            end
        end
    end

    assign en_branch = en_dp;
    assign en_acs    = en_dp;
    assign en_mem    = en_dp;
    assign o_rd_addr = trace_cnt;

endmodule

// File: tb/tb_viterbi_control.sv
// Bench for viterbi_control with FRAME_LEN=4: cycle model plus scoreboard
// for symbols and traceback addresses, a vector table for one full-rate
// frame and hand-written gapped / backpressure / reset / spurious-start runs.
module tb_viterbi_control;

    localparam int FL = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_valid, i_out_ready;
    logic [1:0]    i_Rx;
    logic          o_ready, en_branch, en_acs, en_mem, o_init_pm;
    logic          en_trace, o_busy, o_done;
    logic [1:0]    o_Rx;
    logic [CW-1:0] o_wr_addr, o_rd_addr;

    viterbi_control #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_valid     (i_valid),
        .i_Rx        (i_Rx),
        .o_ready     (o_ready),
        .o_Rx        (o_Rx),
        .en_branch   (en_branch),
        .en_acs      (en_acs),
        .en_mem      (en_mem),
        .o_wr_addr   (o_wr_addr),
        .o_init_pm   (o_init_pm),
        .i_out_ready (i_out_ready),
        .en_trace    (en_trace),
        .o_rd_addr   (o_rd_addr),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    rx;
        logic [CW-1:0] addr;
    } sb_t;

    typedef struct {
        logic st, v;
        logic [1:0] rx;
        logic ordy;
        logic e_ready, e_en, e_trace, e_done;
    } vec_t;

    sb_t     sb_q[$];
    int      tr_q[$];
    int      n_vec = 0;
    int      n_err = 0;

    logic m_busy, m_init, m_ready, m_en, m_flush, m_trace, m_done;
    int   exp_wr;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_init = 0; m_ready = 0; m_en = 0;
        m_flush = 0; m_trace = 0; m_done = 0; exp_wr = 0;
        sb_q.delete();
        tr_q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, int'(o_ready), 0);
        chk({tag, "_rx"}, int'(o_Rx), 0);
        chk({tag, "_en_branch"}, int'(en_branch), 0);
        chk({tag, "_en_acs"}, int'(en_acs), 0);
        chk({tag, "_en_mem"}, int'(en_mem), 0);
        chk({tag, "_wr_addr"}, int'(o_wr_addr), 0);
        chk({tag, "_init_pm"}, int'(o_init_pm), 0);
        chk({tag, "_en_trace"}, int'(en_trace), 0);
        chk({tag, "_rd_addr"}, int'(o_rd_addr), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
    endtask

    // Compare this cycle against the model, then advance the model using
    // the inputs that the next rising edge will see.
    task automatic monitor();
        logic acc, last, popped0, n_init, n_busy, n_ready, n_trace;
        sb_t  e;
        chk("busy", int'(o_busy), int'(m_busy));
        chk("init_pm", int'(o_init_pm), int'(m_init));
        chk("ready", int'(o_ready), int'(m_ready));
        chk("en_branch", int'(en_branch), int'(m_en));
        chk("en_acs", int'(en_acs), int'(m_en));
        chk("en_mem", int'(en_mem), int'(m_en));
        chk("en_trace", int'(en_trace), int'(m_trace && i_out_ready));
        chk("done", int'(o_done), int'(m_done));
        if (m_en) begin
            if (sb_q.size() == 0) begin
                chk("sym_sb_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("o_Rx", int'(o_Rx), int'(e.rx));
                chk("wr_addr", int'(o_wr_addr), int'(e.addr));
            end
        end
        popped0 = 1'b0;
        if (m_trace) begin
            if (tr_q.size() == 0) begin
                chk("trace_sb_empty", 1, 0);
            end else begin
                chk("rd_addr", int'(o_rd_addr), tr_q[0]);
                if (i_out_ready) begin
                    popped0 = (tr_q[0] == 0);
                    void'(tr_q.pop_front());
                end
            end
        end
        if (m_init) begin
            exp_wr = 0;
            sb_q.delete();
        end
        acc  = m_ready && i_valid;
        last = acc && (exp_wr == FL - 1);
        if (acc) begin
            sb_q.push_back('{rx: i_Rx, addr: CW'(exp_wr)});
            exp_wr++;
        end
        if (m_flush) begin
            for (int a = FL - 1; a >= 0; a--) tr_q.push_back(a);
        end
        n_init  = i_start && !m_busy;
        n_busy  = (m_busy && !m_done) || n_init;
        n_ready = m_init || (m_ready && !last);
        n_trace = m_flush || (m_trace && !popped0);
        m_done  = popped0;
        m_flush = last;
        m_trace = n_trace;
        m_en    = acc;
        m_ready = n_ready;
        m_init  = n_init;
        m_busy  = n_busy;
    endtask

    task automatic tick(input logic st, input logic v, input logic [1:0] rx, input logic ordy);
        @(negedge clk);
        i_start     = st;
        i_valid     = v;
        i_Rx        = rx;
        i_out_ready = ordy;
        #2;
        monitor();
    endtask

    function automatic vec_t mkv(input logic st, input logic v, input logic [1:0] rx,
                                 input logic ordy, input logic er, input logic ee,
                                 input logic et, input logic ed);
        vec_t r;
        r.st = st; r.v = v; r.rx = rx; r.ordy = ordy;
        r.e_ready = er; r.e_en = ee; r.e_trace = et; r.e_done = ed;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Full-rate frame: start, INIT, 4 symbols, FLUSH, 4 trace steps, DONE, IDLE.
        tbl[0]  = mkv(1, 0, 2'd0, 1, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 2'd0, 1, 0, 0, 0, 0);
        tbl[2]  = mkv(0, 1, 2'd0, 1, 1, 0, 0, 0);
        tbl[3]  = mkv(0, 1, 2'd1, 1, 1, 1, 0, 0);
        tbl[4]  = mkv(0, 1, 2'd2, 1, 1, 1, 0, 0);
        tbl[5]  = mkv(0, 1, 2'd3, 1, 1, 1, 0, 0);
        tbl[6]  = mkv(0, 0, 2'd0, 1, 0, 1, 0, 0);
        tbl[7]  = mkv(0, 0, 2'd0, 1, 0, 0, 1, 0);
        tbl[8]  = mkv(0, 0, 2'd0, 1, 0, 0, 1, 0);
        tbl[9]  = mkv(0, 0, 2'd0, 1, 0, 0, 1, 0);
        tbl[10] = mkv(0, 0, 2'd0, 1, 0, 0, 1, 0);
        tbl[11] = mkv(0, 0, 2'd0, 1, 0, 0, 0, 1);
        tbl[12] = mkv(0, 0, 2'd0, 1, 0, 0, 0, 0);

        rst = 1'b0; i_start = 0; i_valid = 0; i_Rx = 0; i_out_ready = 0;
        model_reset();
        #12;
        check_zero("por");
        @(negedge clk);
        rst = 1'b1;

        // Idle with i_valid asserted alone: nothing may happen.
        for (int k = 0; k < 6; k++) tick(0, 1, 2'(k), 1);

        // Mid-frame reset after two accepted symbols.
        tick(1, 0, 2'd0, 0);
        tick(0, 0, 2'd0, 0);
        tick(0, 1, 2'd2, 0);
        tick(0, 1, 2'd1, 0);
        tick(0, 0, 2'd0, 0);
        #1;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        tick(0, 0, 2'd0, 0);
        tick(0, 0, 2'd0, 0);
        #1;
        rst = 1'b1;

        // Table-driven full-rate frame; also proves a fresh start after reset.
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].st, tbl[i].v, tbl[i].rx, tbl[i].ordy);
            chk($sformatf("tbl%0d_ready", i), int'(o_ready), int'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_en", i), int'(en_branch), int'(tbl[i].e_en));
            chk($sformatf("tbl%0d_trace", i), int'(en_trace), int'(tbl[i].e_trace));
            chk($sformatf("tbl%0d_done", i), int'(o_done), int'(tbl[i].e_done));
        end

        // Gapped input with spurious starts during DECODE and TRACE; the
        // valid seen during INIT must be ignored.
        tick(1, 0, 2'd0, 1);
        tick(0, 1, 2'd3, 1);
        for (int k = 0; k < 8; k++) tick(k == 3, (k % 2) == 0, 2'(3 - k / 2), 1);
        for (int k = 0; k < 7; k++) tick(k == 2, 1, 2'd1, 1);

        // Traceback backpressure: three stalled cycles at address 2.
        tick(1, 0, 2'd0, 1);
        tick(0, 0, 2'd0, 1);
        for (int k = 0; k < 4; k++) tick(0, 1, 2'(k + 1), 1);
        tick(0, 0, 2'd0, 1);
        begin
            logic ordy_seq [9];
            ordy_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            for (int k = 0; k < 9; k++) tick(0, 0, 2'd0, ordy_seq[k]);
        end
        tick(0, 0, 2'd0, 0);

        chk("sym_sb_drained", sb_q.size(), 0);
        chk("trace_sb_drained", tr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/viterbi_control.md
Name: viterbi_control

Overview:
- Top-level sequencer for the hard-decision Viterbi decoder.
- Accepts received 2-bit symbols through a valid/ready handshake and presents each one to the branch-metric unit with en_branch.
- Drives the ACS/path-metric and survivor-memory enables plus write addresses, then runs traceback over the survivor memory once a frame is complete.
- Sits between the symbol source and the branch_metric/ACS/survivor/traceback datapath.

Parameters:
- FRAME_LEN, 16, symbols per frame; legal range 2..256.
- CNT_W, 8, counter/address width; must satisfy 2^CNT_W >= FRAME_LEN.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- i_start  input  1  single-cycle request to decode one frame; sampled only in IDLE.
- i_valid  input  1  i_Rx carries a symbol.
- i_Rx  input  2  received hard-decision symbol.
- o_ready  output  1  controller accepts a symbol this cycle.
- o_Rx  output  2  registered symbol for branch_metric.
- en_branch  output  1  branch-metric enable.
- en_acs  output  1  ACS/path-metric update enable.
- en_mem  output  1  survivor-memory write enable.
- o_wr_addr  output  CNT_W  survivor write address; equals the symbol index.
- o_init_pm  output  1  one-cycle clear of path metrics (state 0 = 0, others = max).
- i_out_ready  input  1  downstream accepts one traceback step.
- en_trace  output  1  traceback step enable.
- o_rd_addr  output  CNT_W  survivor read address for traceback.
- o_busy  output  1  high whenever state != IDLE.
- o_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (rst=0, async): state=IDLE; all counters 0; every output 0, including o_Rx, the addresses and o_ready.
- States: IDLE, INIT, DECODE, FLUSH, TRACE, DONE.
- IDLE:
  - All enables are 0.
  - i_start=1 → INIT.
  - i_valid is ignored.
- INIT:
  - o_init_pm=1 for exactly one cycle; sym_cnt cleared.
  - Next state DECODE; o_ready is registered 1 from the first DECODE cycle.
- DECODE:
  - A symbol is accepted on (i_valid & o_ready).
  - At acceptance cycle t: o_Rx<=i_Rx and o_wr_addr<=sym_cnt.
  - At cycle t+1: en_branch=en_acs=en_mem=1 for that single cycle.
  - sym_cnt increments at each acceptance.
  - No acceptance → enables low at t+1 and outputs hold.
  - Back-to-back acceptances give continuous enables, one symbol per clock.
  - Accepting symbol FRAME_LEN-1 → o_ready<=0 at the same edge, state → FLUSH.
  - The controller never accepts more than FRAME_LEN symbols.
- FLUSH:
  - Exactly one cycle; carries the enables for the last symbol.
  - trace_cnt<=FRAME_LEN-1.
  - Next state TRACE.
- TRACE:
  - en_trace = (state==TRACE) & i_out_ready. This is the only combinational output path from an input.
  - o_rd_addr = trace_cnt (registered).
  - trace_cnt decrements on each en_trace.
  - i_out_ready=0 stalls: address holds, en_trace=0, no timeout.
  - en_trace while trace_cnt==0 → DONE.
- DONE:
  - o_done=1 for one cycle, then IDLE.
  - o_busy drops in the IDLE cycle.
- Boundaries:
  - i_start while busy is ignored (no queueing).
  - i_valid outside DECODE is ignored.
  - Addresses never wrap: o_wr_addr is at most FRAME_LEN-1; o_rd_addr stops at 0.
  - Reset asserted mid-frame aborts immediately to IDLE; a partial frame is discarded; the next frame needs a fresh i_start, which forces INIT.
- Latency: i_start→first o_ready = 2 cycles. Minimum frame time = 2 + FRAME_LEN + 1 + FRAME_LEN + 1 cycles.

Decomposition:
- Shared package viterbi_pkg holds:
  - the state enumeration (3-bit encoding, IDLE=0);
  - the default FRAME_LEN;
  - the symbol width (2);
  - the path-metric init constant.
- One natural sub-module: frame_counter (CNT_W bits, load/inc/dec/zero-flag). It is instantiated twice, for sym_cnt and trace_cnt.

Test Plan (FRAME_LEN=4):
- Reset then idle: rst=0 then 1, no stimulus → all outputs 0, o_busy=0 indefinitely; i_valid=1 alone → o_ready stays 0.
- Full-rate frame: i_start pulse, i_valid=1 with i_Rx=00,01,10,11 on consecutive cycles:
  - o_init_pm fires 1 cycle after i_start;
  - en_branch high for 4 consecutive cycles with o_Rx=00,01,10,11 and o_wr_addr=0,1,2,3;
  - o_rd_addr=3,2,1,0 with en_trace;
  - o_done exactly one cycle after the addr-0 step.
- Gapped input: i_valid toggled 1,0,1,0,... → enables pulse only the cycle after each acceptance; o_wr_addr stays contiguous 0..3; o_ready drops after the 4th acceptance.
- Traceback backpressure: i_out_ready=0 for 3 cycles at o_rd_addr=2 → en_trace=0 and o_rd_addr holds 2; resume → sequence continues 2,1,0.
- Mid-frame reset: rst=0 after 2 accepted symbols → all outputs 0 asynchronously; after release plus a new i_start → o_init_pm fires and o_wr_addr restarts at 0.
- Spurious start: i_start pulsed during DECODE and TRACE → no state change, frame completes normally, single o_done.
